// File: rtl/tag_issuer.sv
//==============================================================================
// Module   : tag_issuer
// Purpose  : Drives three event-tag lanes toward the tag-disagreement checker.
//            An accepted trigger emits a tag pulse of width+1 cycles on all
//            enabled lanes, followed by at least GAP_CYCLES all-low cycles.
//            A clear from the checker forces all lanes low and holds them
//            quiet for holdoff+1 clear-low cycles before triggers are
//            accepted again. Completed resyncs and dropped triggers are
//            counted with saturating 8-bit counters.
// Ports    : clk, rst (async, active-high)
//            trig       - trigger request, one accept per rising sequence
//            mask       - 1 disables lane 2, latched on accept
//            clear      - resync request, overrides trig
//            width      - tag pulse length minus one
//            holdoff    - quiet period length minus one (clear-low cycles)
//            tag0/1/2   - registered tag lanes
//            busy       - high whenever the FSM is not IDLE
//            resync_cnt - completed resyncs, saturating
//            drop_cnt   - ignored triggers, saturating
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tag_issuer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic       mask,
  input  logic       clear,
  input  logic [3:0] width,
  input  logic [7:0] holdoff,
  output logic       tag0,
  output logic       tag1,
  output logic       tag2,
  output logic       busy,
  output logic [7:0] resync_cnt,
  output logic [7:0] drop_cnt
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EMIT   = 2'd1,
    S_GAP    = 2'd2,
    S_RESYNC = 2'd3
  } state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_pcnt,  w_pcnt;
  logic [GW-1:0] r_gcnt,  w_gcnt;
  logic [7:0]    r_hcnt,  w_hcnt;
  logic          r_mask,  w_mask;
  logic          r_trig_q;
  logic          r_tag01, w_tag01;
  logic          r_tag2,  w_tag2;
  logic [7:0]    r_resync, r_drop;
  logic          w_accept, w_drop, w_resync_inc;

  // A trigger level that stays high only produces one accept: acceptance
  // needs trig seen low on the previous edge.
  assign w_accept = trig & ~r_trig_q;

  // Any trig sampled outside IDLE, or blocked by a coincident clear, is lost.
  assign w_drop = trig & (clear | (r_state != S_IDLE));

  always_comb begin
    w_next       = r_state;
    w_pcnt       = r_pcnt;
    w_gcnt       = r_gcnt;
    w_hcnt       = r_hcnt;
    w_mask       = r_mask;
    w_tag01      = 1'b0;
    w_tag2       = 1'b0;
    w_resync_inc = 1'b0;
    if (clear) begin
      // Clear wins everywhere; an interrupted pulse is abandoned.
      w_next = S_RESYNC;
      w_hcnt = holdoff;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_next  = S_EMIT;
            w_pcnt  = width;
            w_mask  = mask;
            w_tag01 = 1'b1;
            w_tag2  = ~mask;
          end
        end
        S_EMIT: begin
          if (r_pcnt == 4'd0) begin
            w_next = S_GAP;
            w_gcnt = GW'(GAP_CYCLES - 1);
          end else begin
            w_pcnt  = r_pcnt - 4'd1;
            w_tag01 = 1'b1;
            w_tag2  = ~r_mask;
          end
        end
        S_GAP: begin
          if (r_gcnt == '0) begin
            w_next = S_IDLE;
          end else begin
            w_gcnt = r_gcnt - GW'(1);
          end
        end
        S_RESYNC: begin
          if (r_hcnt == 8'd0) begin
            w_next       = S_IDLE;
            w_resync_inc = 1'b1;
          end else begin
            w_hcnt = r_hcnt - 8'd1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pcnt   <= 4'd0;
      r_gcnt   <= '0;
      r_hcnt   <= 8'd0;
      r_mask   <= 1'b0;
      r_trig_q <= 1'b0;
      r_tag01  <= 1'b0;
      r_tag2   <= 1'b0;
      r_resync <= 8'd0;
      r_drop   <= 8'd0;
    end else begin
      r_state  <= w_next;
      r_pcnt   <= w_pcnt;
      r_gcnt   <= w_gcnt;
      r_hcnt   <= w_hcnt;
      r_mask   <= w_mask;
      r_trig_q <= trig;
      r_tag01  <= w_tag01;
      r_tag2   <= w_tag2;
      if (w_resync_inc && (r_resync != 8'hFF)) r_resync <= r_resync + 8'd1;
      if (w_drop && (r_drop != 8'hFF))         r_drop   <= r_drop + 8'd1;
    end
  end

  assign tag0       = r_tag01;
  assign tag1       = r_tag01;
  assign tag2       = r_tag2;
  assign busy       = (r_state != S_IDLE);
  assign resync_cnt = r_resync;
  assign drop_cnt   = r_drop;

endmodule

`default_nettype wire
